// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM state codes,
// line geometry and address field helpers.
package dcache_pkg;

    localparam int unsigned LINE_BITS    = 128;
    localparam int unsigned WORD_BITS    = 32;
    localparam int unsigned WORD_OFF_LSB = 2;
    localparam int unsigned WORD_OFF_MSB = 3;
    localparam int unsigned INDEX_LSB    = 4;

    localparam logic [1:0] StIdle       = 2'd0;
    localparam logic [1:0] StWbWait     = 2'd1;
    localparam logic [1:0] StRefillWait = 2'd2;

    function automatic int unsigned index_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned lines);
        return 32 - INDEX_LSB - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the data cache: one combinational read port,
// a word-write port for store hits and a line-write port for refills.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = index_bits(LINES),
    parameter int unsigned TAG_W = tag_bits(LINES)
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic [IDX_W-1:0]     rd_index,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,

    input  logic                 word_we,
    input  logic [IDX_W-1:0]     word_index,
    input  logic [1:0]           word_off,
    input  logic [WORD_BITS-1:0] word_data,

    input  logic                 line_we,
    input  logic [IDX_W-1:0]     line_index,
    input  logic [TAG_W-1:0]     line_tag,
    input  logic [LINE_BITS-1:0] line_data
);

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    // Refill and store hit never coincide; refill is given priority regardless.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (line_we && line_index == IDX_W'(i)) begin
                    valid_q[i] <= 1'b1;
                    dirty_q[i] <= 1'b0;
                    tag_q[i]   <= line_tag;
                    data_q[i]  <= line_data;
                end else if (word_we && word_index == IDX_W'(i)) begin
                    dirty_q[i] <= 1'b1;
                    data_q[i][{word_off, 5'b0} +: WORD_BITS] <= word_data;
                end
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller for one load/store
// lane: combinational hits, stalling write-back/refill on misses over a 128-bit memory.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_stall,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    localparam int unsigned IDX_W = index_bits(LINES);
    localparam int unsigned TAG_W = tag_bits(LINES);

    logic [1:0]           state_q, state_d;
    logic [31:0]          miss_addr_q, miss_addr_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]     cpu_index;
    logic [TAG_W-1:0]     cpu_tag;
    logic [1:0]           cpu_off;
    logic [31:0]          cpu_line_addr;
    logic                 unused_byte_bits;

    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_data;

    logic                 hit;
    logic                 req;
    logic                 word_we;
    logic                 line_we;

    assign cpu_index        = cpu_addr[INDEX_LSB +: IDX_W];
    assign cpu_tag          = cpu_addr[31 -: TAG_W];
    assign cpu_off          = cpu_addr[WORD_OFF_MSB:WORD_OFF_LSB];
    assign cpu_line_addr    = {cpu_addr[31:INDEX_LSB], 4'b0};
    assign unused_byte_bits = ^cpu_addr[1:0];

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_index   (cpu_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .word_we    (word_we),
        .word_index (cpu_index),
        .word_off   (cpu_off),
        .word_data  (cpu_wdata),
        .line_we    (line_we),
        .line_index (miss_addr_q[INDEX_LSB +: IDX_W]),
        .line_tag   (miss_addr_q[31 -: TAG_W]),
        .line_data  (mem_rdata)
    );

    assign hit       = rd_valid && (rd_tag == cpu_tag);
    assign req       = cpu_read || cpu_write;
    assign word_we   = (state_q == StIdle) && cpu_write && hit;
    assign cpu_rdata = rd_data[{cpu_off, 5'b0} +: WORD_BITS];
    assign cpu_stall = (state_q != StIdle) || (req && !hit);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;

        case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    miss_addr_d = cpu_line_addr;
                    if (rd_valid && rd_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, cpu_index, 4'b0};
                        mem_wdata_d = rd_data;
                        state_d     = StWbWait;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = cpu_line_addr;
                        state_d    = StRefillWait;
                    end
                end
            end
            StWbWait: begin
                // The miss line comes from the latch: the lane may have dropped its request.
                if (mem_ready) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = miss_addr_q;
                    state_d    = StRefillWait;
                end
            end
            StRefillWait: begin
                if (mem_ready) begin
                    line_we = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: transaction-level cache model, latency-L memory responder,
// directed scenarios with literal expectations, then randomized accesses.
module tb_dcache_controller;

    logic         clk;
    logic         reset_n;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    dcache_controller #(.LINES(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: absent lines read as an address-derived pattern.
    logic [127:0] mem [logic [31:0]];

    function automatic logic [127:0] mem_get(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 32'hC0DE0003, a ^ 32'hC0DE0002, a ^ 32'hC0DE0001, a ^ 32'hC0DE0000};
    endfunction

    // Cache model: per-index valid/dirty/tag/line.
    bit           m_valid [16];
    bit           m_dirty [16];
    int unsigned  m_tag   [16];
    logic [127:0] m_data  [16];

    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [127:0] data;
    } txn_t;

    txn_t exp_q [$];

    int           lat;
    bit           idle_ok;
    bit           cur_active;
    bit           cur_check_rd;
    logic [31:0]  exp_rdata;
    logic [31:0]  last_wr_addr;
    logic [127:0] last_wr_data;

    task automatic push_exp(input bit w, input logic [31:0] a, input logic [127:0] d);
        txn_t t;
        t.is_write = w;
        t.addr     = a;
        t.data     = d;
        exp_q.push_back(t);
    endtask

    // Memory responder: answers each request pulse with mem_ready L cycles later.
    initial begin
        logic [31:0] la;
        bit          wrq;
        int          l;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset_n && (mem_read || mem_write)) begin
                la  = mem_addr;
                wrq = mem_write;
                l   = lat;
                if (wrq) begin
                    mem[la]      = mem_wdata;
                    last_wr_addr = la;
                    last_wr_data = mem_wdata;
                end
                repeat (l) @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_rdata = wrq ? {4{$urandom()}} : mem_get(la);
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    // Compare process: memory-side pulses against the expected queue, load data on
    // completion, and no stall while the lane is quiet.
    txn_t cmp_t;
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_read && mem_write) check("mem_rd_wr_exclusive", 1'b1, 1'b0);
            if (mem_read || mem_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mem_req", {mem_write, mem_addr}, '0);
                end else begin
                    cmp_t = exp_q.pop_front();
                    check("mem_req_kind", mem_write, cmp_t.is_write);
                    check("mem_addr", mem_addr, cmp_t.addr);
                    if (cmp_t.is_write) check("mem_wdata", mem_wdata, cmp_t.data);
                end
            end
            if (cur_active && cur_check_rd && !cpu_stall) check("cpu_rdata", cpu_rdata, exp_rdata);
            if (idle_ok && !cpu_read && !cpu_write) check("idle_stall", cpu_stall, 1'b0);
        end
    end

    // One CPU access: predict traffic, stall length and data, then drive until done.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, output int stall_cycles,
                             output logic [31:0] rdata);
        int unsigned idx;
        int unsigned tg;
        int unsigned off;
        int          exp_stall;
        bit          done;
        logic [31:0] la;
        idx       = (addr >> 4) & 32'hF;
        tg        = addr >> 8;
        off       = (addr >> 2) & 32'h3;
        la        = addr & 32'hFFFF_FFF0;
        exp_stall = 0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                push_exp(1'b1, (m_tag[idx] << 8) | (idx << 4), m_data[idx]);
                exp_stall = 2 * lat + 3;
            end else begin
                exp_stall = lat + 2;
            end
            push_exp(1'b0, la, '0);
            m_data[idx]  = mem_get(la);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (wr) begin
            m_data[idx][off*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        exp_rdata    = m_data[idx][off*32 +: 32];
        cur_check_rd = rd && !wr;
        cur_active   = 1'b1;
        cpu_read     = rd;
        cpu_write    = wr;
        cpu_addr     = addr;
        cpu_wdata    = wd;
        stall_cycles = 0;
        rdata        = '0;
        done         = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done  = 1'b1;
                rdata = cpu_rdata;
            end else begin
                stall_cycles++;
            end
        end
        check("access_completed", done, 1'b1);
        check("stall_cycles", stall_cycles, exp_stall);
        @(posedge clk);
        #1;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        cur_active = 1'b0;
        check("pending_mem_reqs", exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          st;
        logic [31:0] rv;
        bit          seen;
        reset_n      = 1'b0;
        cpu_read     = 1'b0;
        cpu_write    = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        lat          = 19;
        idle_ok      = 1'b0;
        cur_active   = 1'b0;
        cur_check_rd = 1'b0;
        exp_rdata    = '0;
        last_wr_addr = '0;
        last_wr_data = '0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
            m_data[i]  = '0;
        end
        mem[32'h40] = {32'd4, 32'd3, 32'd2, 32'd1};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_mem_write", mem_write, 1'b0);
        check("reset_mem_addr", mem_addr, '0);
        check("reset_mem_wdata", mem_wdata, '0);
        check("reset_cpu_stall", cpu_stall, 1'b0);
        idle_ok = 1'b1;
        @(posedge clk);
        #1;

        // Clean miss at L=19, then a hit in the filled line.
        do_access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("fill_stall_21", st, 21);
        check("fill_rdata_1", rv, 32'd1);
        do_access(1'b1, 1'b0, 32'h44, '0, st, rv);
        check("hit_stall_0", st, 0);
        check("hit_rdata_2", rv, 32'd2);

        // Store hit, then read it back.
        do_access(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, st, rv);
        check("store_hit_stall_0", st, 0);
        do_access(1'b1, 1'b0, 32'h48, '0, st, rv);
        check("store_readback", rv, 32'hDEADBEEF);

        // Conflict miss with dirty victim.
        do_access(1'b1, 1'b0, 32'h140, '0, st, rv);
        check("dirty_miss_stall_41", st, 41);
        check("victim_addr", last_wr_addr, 32'h40);
        check("victim_data", last_wr_data, {32'd4, 32'hDEADBEEF, 32'd2, 32'd1});

        // Read and write together on a hit: the write wins and dirties the line.
        lat = 3;
        do_access(1'b1, 1'b1, 32'h144, 32'h12345678, st, rv);
        check("rdwr_hit_stall_0", st, 0);
        do_access(1'b1, 1'b0, 32'h40, '0, st, rv);
        check("rdwr_evict_stall", st, 9);
        check("rdwr_evict_addr", last_wr_addr, 32'h140);
        check("rdwr_evict_word1", last_wr_data[63:32], 32'h12345678);

        // Reset during REFILL_WAIT; the stale mem_ready must be ignored.
        lat = 8;
        push_exp(1'b0, 32'h280, '0);
        cpu_read = 1'b1;
        cpu_addr = 32'h280;
        seen     = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0) seen = 1'b1;
        end
        check("abort_req_seen", seen, 1'b1);
        #1;
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        idle_ok  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_ok = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        repeat (12) @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'h280, '0, st, rv);
        check("post_abort_miss_stall", st, 10);

        // Long memory latency: stall held, exactly one request pulse.
        lat = 100;
        do_access(1'b1, 1'b0, 32'h3C0, '0, st, rv);
        check("long_latency_stall", st, 102);

        // Randomized accesses over a small conflict-heavy address space.
        for (int n = 0; n < 300; n++) begin
            int unsigned op;
            logic [31:0] a;
            lat = $urandom_range(1, 6);
            op  = $urandom_range(0, 2);
            a   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
                | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            do_access(op != 1, op != 0, a, $urandom(), st, rv);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
